axi4_stream_arbiter: RTL and testbench
======================================

// Module: axi4_stream_arbiter
// PURPOSE
//  Packet-aware round-robin arbiter sharing one AXI4-Stream master port among NUM_PORTS
//  slave streams (e.g. request sources feeding the openHMC TX path). Grant is locked for a
//  whole packet, from first beat to the EOP beat flagged in TUSER, so packets never interleave.
//  Data path is combinational through a registered grant; output obeys AXI4-Stream hold rules.
// PARAMETERS
//  NUM_PORTS    4   number of slave (requester) streams, >=2
//  DATA_BYTES   16  TDATA width in bytes (TDATA = 8*DATA_BYTES bits)
//  TUSER_WIDTH  16  TUSER width
//  EOP_BIT      0   TUSER bit index marking last beat of a packet (0..TUSER_WIDTH-1)
// PORTS
//  ACLK      in   1                        clock, all signals sampled on rising edge
//  ARESET_N  in   1                        reset, asynchronous, active-low
//  S_TVALID  in   NUM_PORTS                per-port valid
//  S_TREADY  out  NUM_PORTS                per-port ready
//  S_TDATA   in   NUM_PORTS*8*DATA_BYTES   port i at [i*8*DATA_BYTES +: 8*DATA_BYTES]
//  S_TUSER   in   NUM_PORTS*TUSER_WIDTH    port i at [i*TUSER_WIDTH +: TUSER_WIDTH]
//  M_TVALID  out  1                        shared output valid
//  M_TREADY  in   1                        shared output ready
//  M_TDATA   out  8*DATA_BYTES             shared output data
//  M_TUSER   out  TUSER_WIDTH              shared output sideband
//  GRANT     out  NUM_PORTS                one-hot current owner, 0 when idle
//  BUSY      out  1                        1 while a packet is in flight (state LOCKED)
// BEHAVIOUR
//  Reset (ARESET_N=0, async): state IDLE, GRANT=0, rr pointer=0, BUSY=0; hence
//   M_TVALID=0, S_TREADY=0, M_TDATA/M_TUSER=0.
//  FSM IDLE: M_TVALID=0, all S_TREADY=0. If any S_TVALID, pick first set index searching
//   rr_ptr, rr_ptr+1, ... mod NUM_PORTS; register GRANT, go LOCKED. Arbitration latency
//   1 cycle: first beat can transfer earliest the cycle after S_TVALID seen in IDLE.
//  FSM LOCKED (owner g): M_TVALID=S_TVALID[g], M_TDATA/M_TUSER = port g fields,
//   S_TREADY[g]=M_TREADY, S_TREADY[other]=0. M_TDATA/M_TUSER=0 when not LOCKED.
//   On handshake (S_TVALID[g]&M_TREADY) with S_TUSER[g][EOP_BIT]=1: go IDLE, GRANT=0,
//   rr_ptr=(g+1) mod NUM_PORTS. Non-EOP beats and stalls keep LOCKED, grant unchanged.
//  No grant change while owner holds TVALID without TREADY, so TDATA stays stable under
//   backpressure (data-hold rule on master side guaranteed if slaves obey it).
//  Owner deasserting TVALID mid-packet: M_TVALID=0, stay LOCKED; others wait (no timeout).
//  Single-beat packet (EOP on first beat): 1 beat then IDLE; max throughput per packet is
//   N beats in N+1 cycles (one idle arbitration cycle between packets, by design).
//  Requests arriving while LOCKED: ignored until IDLE; fairness: a port that just finished
//   has lowest priority next round. rr_ptr wraps NUM_PORTS-1 -> 0.
//  Reset mid-packet: immediate return to IDLE, partial packet abandoned, no handshake.
//  Combinational paths: M_TREADY->S_TREADY, S_TVALID/TDATA/TUSER->M_*; no ready->valid
//   path (M_TVALID independent of M_TREADY).
// TESTING
//  1 Reset: hold ARESET_N=0 with all S_TVALID=1 -> M_TVALID=0, S_TREADY=0, GRANT=0, BUSY=0.
//  2 Round robin: ports 0..3 each present 1-beat EOP packets continuously, M_TREADY=1 ->
//    output order 0,1,2,3,0,...; one idle cycle between beats; GRANT one-hot each beat.
//  3 Packet lock: port1 sends 4 beats (EOP on 4th), port0 valid throughout -> port1 beats
//    contiguous, port0 granted only after port1 EOP handshake; S_TREADY[0]=0 meanwhile.
//  4 Backpressure: M_TREADY random 50% during 8-beat packet -> M_TDATA stable while
//    M_TVALID&!M_TREADY; all 8 beats delivered in order; data-hold assertion never fires.
//  5 Owner gap: owner drops TVALID for 3 cycles mid-packet -> M_TVALID=0, GRANT unchanged,
//    other ports stalled; packet completes on resume.
//  6 Async reset mid-packet after beat 2 of 5 -> M_TVALID=0 same cycle, GRANT=0; after
//    release, fresh arbitration starting from rr_ptr=0.

Source files
------------

// File: rtl/axi4_stream_arbiter.sv
// Packet-aware round-robin arbiter: NUM_PORTS AXI4-Stream slaves share one master port.
// Grant is held from a packet's first beat through the EOP beat flagged in TUSER.
module axi4_stream_arbiter #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned DATA_BYTES  = 16,
  parameter int unsigned TUSER_WIDTH = 16,
  parameter int unsigned EOP_BIT     = 0
) (
  input  logic                                ACLK,
  input  logic                                ARESET_N,
  input  logic [NUM_PORTS-1:0]                S_TVALID,
  output logic [NUM_PORTS-1:0]                S_TREADY,
  input  logic [NUM_PORTS*8*DATA_BYTES-1:0]   S_TDATA,
  input  logic [NUM_PORTS*TUSER_WIDTH-1:0]    S_TUSER,
  output logic                                M_TVALID,
  input  logic                                M_TREADY,
  output logic [8*DATA_BYTES-1:0]             M_TDATA,
  output logic [TUSER_WIDTH-1:0]              M_TUSER,
  output logic [NUM_PORTS-1:0]                GRANT,
  output logic                                BUSY
);

  localparam int unsigned DataW = 8 * DATA_BYTES;
  localparam int unsigned PtrW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [PtrW-1:0]      owner_q, owner_d;
  logic [PtrW-1:0]      rr_q, rr_d;

  logic [PtrW-1:0]      pick;
  logic                 pick_vld;
  int                   arb_idx;

  logic                 owner_tvalid;
  logic [DataW-1:0]     owner_tdata;
  logic [TUSER_WIDTH-1:0] owner_tuser;
  logic                 locked;
  logic                 eop_hs;

  assign locked = (state_q == StLocked);

  // First requester at or after rr_q, wrapping modulo NUM_PORTS.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    arb_idx  = 0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      arb_idx = (int'(rr_q) + i) % int'(NUM_PORTS);
      if (!pick_vld && S_TVALID[arb_idx]) begin
        pick_vld = 1'b1;
        pick     = PtrW'(arb_idx);
      end
    end
  end

  always_comb begin
    owner_tvalid = 1'b0;
    owner_tdata  = '0;
    owner_tuser  = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (owner_q == PtrW'(i)) begin
        owner_tvalid = S_TVALID[i];
        owner_tdata  = S_TDATA[i*DataW +: DataW];
        owner_tuser  = S_TUSER[i*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  assign eop_hs = locked && owner_tvalid && M_TREADY && owner_tuser[EOP_BIT];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StLocked;
          grant_d = NUM_PORTS'(1) << pick;
          owner_d = pick;
        end
      end
      StLocked: begin
        // Only the EOP handshake releases the grant; stalls and gaps keep it.
        if (eop_hs) begin
          state_d = StIdle;
          grant_d = '0;
          rr_d    = (owner_q == PtrW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    M_TVALID = locked && owner_tvalid;
    M_TDATA  = locked ? owner_tdata : '0;
    M_TUSER  = locked ? owner_tuser : '0;
    S_TREADY = (locked && M_TREADY) ? grant_q : '0;
    GRANT    = grant_q;
    BUSY     = locked;
  end

endmodule

// File: tb/tb_axi4_stream_arbiter.sv
// Bench for axi4_stream_arbiter: vector table, directed packet sequences and a
// randomized run against a round-robin packet model.
module tb_axi4_stream_arbiter;

  localparam int N  = 4;
  localparam int DB = 16;
  localparam int DW = 8 * DB;
  localparam int TW = 16;
  localparam int EB = 0;

  logic            aclk = 1'b0;
  logic            arstn;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*TW-1:0] s_tuser;
  logic            m_tvalid;
  logic            m_tready;
  logic [DW-1:0]   m_tdata;
  logic [TW-1:0]   m_tuser;
  logic [N-1:0]    grant;
  logic            busy;

  int total = 0;
  int bad   = 0;

  axi4_stream_arbiter #(
    .NUM_PORTS  (N),
    .DATA_BYTES (DB),
    .TUSER_WIDTH(TW),
    .EOP_BIT    (EB)
  ) dut (
    .ACLK    (aclk),
    .ARESET_N(arstn),
    .S_TVALID(s_tvalid),
    .S_TREADY(s_tready),
    .S_TDATA (s_tdata),
    .S_TUSER (s_tuser),
    .M_TVALID(m_tvalid),
    .M_TREADY(m_tready),
    .M_TDATA (m_tdata),
    .M_TUSER (m_tuser),
    .GRANT   (grant),
    .BUSY    (busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] sv;
    logic       rdy;
    logic [3:0] eop;
    logic       exp_mv;
    logic [3:0] exp_g;
    logic       exp_busy;
    logic [3:0] exp_sr;
    int         exp_src;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic mv, input logic [3:0] g,
                            input logic b, input logic [3:0] sr, input logic [DW-1:0] d,
                            input logic [TW-1:0] u);
    check({tag, ".mvalid"}, 128'(m_tvalid), 128'(mv));
    check({tag, ".grant"},  128'(grant),    128'(g));
    check({tag, ".busy"},   128'(busy),     128'(b));
    check({tag, ".sready"}, 128'(s_tready), 128'(sr));
    check({tag, ".mdata"},  m_tdata,        d);
    check({tag, ".muser"},  128'(m_tuser),  128'(u));
  endtask

  function automatic logic [DW-1:0] pdata(input int p);
    logic [7:0] b;
    b = 8'hA0 + 8'(p);
    return {DB{b}};
  endfunction

  function automatic logic [DW-1:0] beat(input int base, input int k);
    logic [7:0] b;
    b = 8'(base + k);
    return {DB{b}};
  endfunction

  function automatic logic [TW-1:0] user_of(input logic eop);
    return TW'(eop) << EB;
  endfunction

  task automatic set_port(input int p, input logic v, input logic [DW-1:0] d, input logic eop);
    s_tvalid[p] = v;
    s_tdata[p*DW +: DW] = d;
    s_tuser[p*TW +: TW] = user_of(eop);
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    arstn    = 1'b0;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arstn = 1'b1;
    next_cycle();
  endtask

  // Random-run model: owner port (-1 when idle) and round-robin start index.
  int             m_owner;
  int             m_rr;
  logic [DW-1:0]  cd[N];
  logic           ce[N];

  initial begin
    // in: valid, ready, eop mask; out: mvalid, grant, busy, sready, source port
    vecs[0]  = '{4'b0000, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    vecs[1]  = '{4'b1010, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    vecs[2]  = '{4'b1010, 1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 4'b0000,  1};
    vecs[3]  = '{4'b1010, 1'b1, 4'h0, 1'b1, 4'b0010, 1'b1, 4'b0010,  1};
    vecs[4]  = '{4'b1000, 1'b1, 4'hF, 1'b0, 4'b0010, 1'b1, 4'b0010,  1};
    vecs[5]  = '{4'b1010, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 4'b0010,  1};
    vecs[6]  = '{4'b1011, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    vecs[7]  = '{4'b1011, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 4'b1000,  3};
    vecs[8]  = '{4'b1011, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    vecs[9]  = '{4'b0011, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
    vecs[10] = '{4'b0001, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};
    vecs[11] = '{4'b0001, 1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 4'b0000,  0};
    vecs[12] = '{4'b0000, 1'b0, 4'hF, 1'b0, 4'b0001, 1'b1, 4'b0000,  0};
    vecs[13] = '{4'b0001, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 4'b0001,  0};
    vecs[14] = '{4'b0000, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0, 4'b0000, -1};

    // Reset held with every port requesting.
    arstn    = 1'b0;
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    for (int p = 0; p < N; p++) set_port(p, 1'b1, pdata(p), 1'b1);
    @(negedge aclk);
    check_outs("rst0", 1'b0, 4'b0, 1'b0, 4'b0, '0, '0);
    @(negedge aclk);
    check_outs("rst1", 1'b0, 4'b0, 1'b0, 4'b0, '0, '0);
    s_tvalid = '0;
    arstn = 1'b1;
    next_cycle();

    // Vector table, one record per clock.
    for (int i = 0; i < 15; i++) begin
      for (int p = 0; p < N; p++) set_port(p, vecs[i].sv[p], pdata(p), vecs[i].eop[p]);
      m_tready = vecs[i].rdy;
      @(negedge aclk);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_mv, vecs[i].exp_g, vecs[i].exp_busy,
                 vecs[i].exp_sr,
                 (vecs[i].exp_src < 0) ? '0 : pdata(vecs[i].exp_src),
                 (vecs[i].exp_src < 0) ? '0 : user_of(vecs[i].eop[vecs[i].exp_src]));
      next_cycle();
    end

    // Round robin with all ports offering single-beat packets.
    do_reset();
    for (int p = 0; p < N; p++) set_port(p, 1'b1, pdata(p), 1'b1);
    for (int c = 0; c < 16; c++) begin
      @(negedge aclk);
      if (c % 2 == 0) begin
        check($sformatf("rr%0d.grant", c), 128'(grant), 128'(0));
        check($sformatf("rr%0d.mvalid", c), 128'(m_tvalid), 128'(0));
      end else begin
        check($sformatf("rr%0d.grant", c), 128'(grant), 128'(4'b1 << ((c / 2) % N)));
        check($sformatf("rr%0d.mdata", c), m_tdata, pdata((c / 2) % N));
      end
      next_cycle();
    end

    // Packet lock: port 1 sends four beats while port 0 keeps requesting.
    do_reset();
    set_port(1, 1'b1, beat(8'h10, 0), 1'b0);
    next_cycle();
    set_port(0, 1'b1, pdata(0), 1'b1);
    for (int k = 0; k < 4; k++) begin
      set_port(1, 1'b1, beat(8'h10, k), k == 3);
      @(negedge aclk);
      check($sformatf("lock%0d.grant", k), 128'(grant), 128'(4'b0010));
      check($sformatf("lock%0d.sready", k), 128'(s_tready), 128'(4'b0010));
      check($sformatf("lock%0d.mdata", k), m_tdata, beat(8'h10, k));
      next_cycle();
    end
    set_port(1, 1'b0, '0, 1'b0);
    @(negedge aclk);
    check("lock.gap.grant", 128'(grant), 128'(0));
    next_cycle();
    @(negedge aclk);
    check("lock.next.grant", 128'(grant), 128'(4'b0001));
    check("lock.next.mdata", m_tdata, pdata(0));
    next_cycle();

    // Backpressure on an 8-beat packet from port 2.
    begin
      int k;
      int cyc;
      do_reset();
      k = 0;
      cyc = 0;
      while (k < 8 && cyc < 200) begin
        set_port(2, 1'b1, beat(8'h20, k), k == 7);
        @(negedge aclk);
        if (grant != 4'b0) begin
          check($sformatf("bp%0d.mvalid", cyc), 128'(m_tvalid), 128'(1));
          check($sformatf("bp%0d.mdata", cyc), m_tdata, beat(8'h20, k));
          if (m_tready) k++;
        end
        @(posedge aclk);
        #1;
        m_tready = 1'($urandom % 2);
        cyc++;
      end
      check("bp.beats", 128'(k), 128'(8));
      m_tready = 1'b1;
      set_port(2, 1'b0, '0, 1'b0);
      next_cycle();
    end

    // Owner gap: port 0 drops valid for three cycles mid-packet.
    begin
      int b;
      logic v0;
      do_reset();
      b = 0;
      for (int c = 0; c < 9; c++) begin
        v0 = (c <= 1) || (c == 5) || (c == 6);
        set_port(0, v0, beat(8'h40, b), b == 2);
        set_port(1, 1'b1, pdata(1), 1'b1);
        @(negedge aclk);
        if (c == 0 || c == 7) begin
          check($sformatf("gap%0d.grant", c), 128'(grant), 128'(0));
        end else if (c == 8) begin
          check("gap8.grant", 128'(grant), 128'(4'b0010));
        end else begin
          check($sformatf("gap%0d.grant", c), 128'(grant), 128'(4'b0001));
          check($sformatf("gap%0d.mvalid", c), 128'(m_tvalid), 128'(v0));
          check($sformatf("gap%0d.sready", c), 128'(s_tready), 128'(4'b0001));
          if (v0) begin
            check($sformatf("gap%0d.mdata", c), m_tdata, beat(8'h40, b));
            b++;
          end
        end
        next_cycle();
      end
      s_tvalid = '0;
      next_cycle();
    end

    // Async reset after beat 2 of 5; rr pointer must restart at 0.
    do_reset();
    set_port(2, 1'b1, pdata(2), 1'b1);
    next_cycle();
    next_cycle();
    set_port(2, 1'b0, '0, 1'b0);
    set_port(3, 1'b1, beat(8'h60, 0), 1'b0);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      set_port(3, 1'b1, beat(8'h60, k), 1'b0);
      @(negedge aclk);
      check($sformatf("ar%0d.grant", k), 128'(grant), 128'(4'b1000));
      next_cycle();
    end
    set_port(3, 1'b1, beat(8'h60, 2), 1'b0);
    set_port(0, 1'b1, pdata(0), 1'b1);
    #2;
    arstn = 1'b0;
    #1;
    check_outs("ar.inrst", 1'b0, 4'b0, 1'b0, 4'b0, '0, '0);
    @(negedge aclk);
    arstn = 1'b1;
    next_cycle();
    @(negedge aclk);
    check("ar.after.grant", 128'(grant), 128'(4'b0001));
    check("ar.after.mdata", m_tdata, pdata(0));
    next_cycle();

    // Randomized traffic against the packet model.
    do_reset();
    m_owner = -1;
    m_rr    = 0;
    for (int p = 0; p < N; p++) begin
      cd[p] = {$urandom, $urandom, $urandom, $urandom};
      ce[p] = ($urandom % 3) == 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < N; p++) set_port(p, ($urandom % 100) < 60, cd[p], ce[p]);
      m_tready = ($urandom % 100) < 70;
      @(negedge aclk);
      if (m_owner < 0) begin
        check_outs($sformatf("rnd%0d", c), 1'b0, 4'b0, 1'b0, 4'b0, '0, '0);
      end else begin
        check_outs($sformatf("rnd%0d", c), s_tvalid[m_owner], 4'(1 << m_owner), 1'b1,
                   m_tready ? 4'(1 << m_owner) : 4'b0, cd[m_owner], user_of(ce[m_owner]));
      end
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_owner < 0 && s_tvalid[(m_rr + i) % N]) m_owner = (m_rr + i) % N;
        end
      end else if (s_tvalid[m_owner] && m_tready) begin
        int p;
        p = m_owner;
        if (ce[p]) begin
          m_rr    = (p + 1) % N;
          m_owner = -1;
        end
        cd[p] = {$urandom, $urandom, $urandom, $urandom};
        ce[p] = ($urandom % 3) == 0;
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
